// File: rtl/stream_demux_pkg.sv
// Shared types and constants for the stream demultiplexer and its skid buffers.
package stream_demux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FWD,
        ST_DROP
    } demux_state_e;

    localparam int unsigned SKID_DEPTH = 2;

endpackage

// File: rtl/demux_skid.sv
// Two-entry skid buffer: one-cycle latency, full throughput, ready registered from !full.
module demux_skid
    import stream_demux_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic [WIDTH-1:0] mem_q [SKID_DEPTH];
    logic             wr_q;
    logic             rd_q;
    logic [1:0]       cnt_q;
    logic [1:0]       cnt_d;
    logic             full_q;
    logic             push;
    logic             pop;

    always_comb begin
        push  = in_valid && !full_q;
        pop   = (cnt_q != 2'd0) && out_ready;
        cnt_d = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + 2'd1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < SKID_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
            cnt_q  <= 2'd0;
            full_q <= 1'b0;
        end else begin
            if (push) begin
                mem_q[wr_q] <= in_data;
                wr_q        <= ~wr_q;
            end
            if (pop) begin
                rd_q <= ~rd_q;
            end
            cnt_q  <= cnt_d;
            full_q <= (cnt_d == 2'(SKID_DEPTH));
        end
    end

    assign in_ready  = !full_q;
    assign out_valid = (cnt_q != 2'd0);
    assign out_data  = mem_q[rd_q];

endmodule

// File: rtl/stream_demux.sv
// 1-to-N packet demultiplexer: destination latched on the first beat, out-of-range packets sunk.
module stream_demux
    import stream_demux_pkg::*;
#(
    parameter  int DATA_W  = 8,
    parameter  int NUM_OUT = 2,
    parameter  int USE_REG = 0,
    localparam int SEL_W   = $clog2(NUM_OUT)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_last,
    input  logic [SEL_W-1:0]          in_sel,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ready,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_last,
    output logic                      busy,
    output logic                      sel_err
);

    demux_state_e       state_q;
    logic [SEL_W-1:0]   locked_q;
    logic               busy_q;
    logic [SEL_W-1:0]   route;
    logic               route_ok;
    logic               steer;
    logic               accept;
    logic [NUM_OUT-1:0] down_ready;
    logic [NUM_OUT-1:0] dn_valid;

    always_comb begin
        route    = (state_q == ST_IDLE) ? in_sel : locked_q;
        route_ok = (int'(route) < NUM_OUT);
        steer    = route_ok && (state_q != ST_DROP);
        // Drop and error cases sink the beat regardless of downstream ready.
        in_ready = steer ? down_ready[route] : 1'b1;
        sel_err  = (state_q == ST_IDLE) && in_valid && !route_ok;
        accept   = in_valid && in_ready;
    end

    for (genvar i = 0; i < NUM_OUT; i++) begin : g_steer
        assign dn_valid[i] = in_valid && steer && (route == SEL_W'(i));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            locked_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && !route_ok) begin
                        if (!in_last) begin
                            state_q <= ST_DROP;
                            busy_q  <= 1'b1;
                        end
                    end else if (accept && !in_last) begin
                        locked_q <= in_sel;
                        state_q  <= ST_FWD;
                        busy_q   <= 1'b1;
                    end
                end
                ST_FWD, ST_DROP: begin
                    if (accept && in_last) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;

    if (USE_REG == 0) begin : g_comb
        assign out_valid  = dn_valid;
        assign down_ready = out_ready;
        assign out_last   = {NUM_OUT{in_last}};
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
            assign out_data[i*DATA_W +: DATA_W] = in_data;
        end
    end else begin : g_reg
        for (genvar i = 0; i < NUM_OUT; i++) begin : g_out
            logic [DATA_W:0] skid_out;

            demux_skid #(
                .WIDTH(DATA_W + 1)
            ) u_skid (
                .clk      (clk),
                .rst      (rst),
                .in_valid (dn_valid[i]),
                .in_ready (down_ready[i]),
                .in_data  ({in_last, in_data}),
                .out_valid(out_valid[i]),
                .out_ready(out_ready[i]),
                .out_data (skid_out)
            );

            assign out_last[i]                  = skid_out[DATA_W];
            assign out_data[i*DATA_W +: DATA_W] = skid_out[DATA_W-1:0];
        end
    end

endmodule

// File: tb/tb_stream_demux.sv
// Scoreboard bench for stream_demux across combinational and registered configurations.
module tb_stream_demux;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int c_acc = 0;
    int b_err_cnt = 0;

    always @(posedge clk) cyc++;

    // DUT A: NUM_OUT=4, combinational
    logic        a_valid, a_ready, a_last, a_busy, a_sel_err;
    logic [7:0]  a_data;
    logic [1:0]  a_sel;
    logic [3:0]  a_out_valid, a_out_ready, a_out_last;
    logic [31:0] a_out_data;

    // DUT B: NUM_OUT=3, combinational
    logic        b_valid, b_ready, b_last, b_busy, b_sel_err;
    logic [7:0]  b_data;
    logic [1:0]  b_sel;
    logic [2:0]  b_out_valid, b_out_ready, b_out_last;
    logic [23:0] b_out_data;

    // DUT C: NUM_OUT=2, registered
    logic        c_valid, c_ready, c_last, c_busy, c_sel_err;
    logic [7:0]  c_data;
    logic [0:0]  c_sel;
    logic [1:0]  c_out_valid, c_out_ready, c_out_last;
    logic [15:0] c_out_data;

    stream_demux #(.DATA_W(8), .NUM_OUT(4), .USE_REG(0)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_data(a_data),
        .in_last(a_last), .in_sel(a_sel), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .out_last(a_out_last), .busy(a_busy), .sel_err(a_sel_err)
    );

    stream_demux #(.DATA_W(8), .NUM_OUT(3), .USE_REG(0)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data),
        .in_last(b_last), .in_sel(b_sel), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .out_last(b_out_last), .busy(b_busy), .sel_err(b_sel_err)
    );

    stream_demux #(.DATA_W(8), .NUM_OUT(2), .USE_REG(1)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_data(c_data),
        .in_last(c_last), .in_sel(c_sel), .out_valid(c_out_valid), .out_ready(c_out_ready),
        .out_data(c_out_data), .out_last(c_out_last), .busy(c_busy), .sel_err(c_sel_err)
    );

    logic [8:0] qa [4][$];
    logic [8:0] qb [3][$];
    logic [8:0] qc [2][$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: bound expired or unexpected beat (t=%0t)", name, $time);
    endtask

    // Monitor: pops the expected beat whenever an output handshake is pending.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (a_out_valid[i] && a_out_ready[i]) begin
                    if (qa[i].size() == 0) fail($sformatf("a_unexpected_out%0d", i));
                    else chk($sformatf("a_beat_out%0d", i),
                             32'({a_out_last[i], a_out_data[i*8 +: 8]}), 32'(qa[i].pop_front()));
                end
            end
            for (int i = 0; i < 3; i++) begin
                if (b_out_valid[i] && b_out_ready[i]) begin
                    if (qb[i].size() == 0) fail($sformatf("b_unexpected_out%0d", i));
                    else chk($sformatf("b_beat_out%0d", i),
                             32'({b_out_last[i], b_out_data[i*8 +: 8]}), 32'(qb[i].pop_front()));
                end
            end
            for (int i = 0; i < 2; i++) begin
                if (c_out_valid[i] && c_out_ready[i]) begin
                    if (qc[i].size() == 0) fail($sformatf("c_unexpected_out%0d", i));
                    else chk($sformatf("c_beat_out%0d", i),
                             32'({c_out_last[i], c_out_data[i*8 +: 8]}), 32'(qc[i].pop_front()));
                end
            end
            if (b_sel_err) b_err_cnt++;
        end
    end

    // dest < 0 means the beat is expected to be sunk.
    task automatic send_a(input int sel, input logic [7:0] d, input logic last, input int dest);
        if (dest >= 0) qa[dest].push_back({last, d});
        a_valid = 1'b1; a_sel = 2'(sel); a_data = d; a_last = last;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (a_ready) break;
            if (n > 50) begin fail("a_timeout"); break; end
        end
        chk("a_latency0", 32'(a_out_valid), (dest >= 0) ? (32'(1) << dest) : 32'(0));
        @(posedge clk); #1;
        a_valid = 1'b0;
    endtask

    task automatic send_b(input int sel, input logic [7:0] d, input logic last, input int dest,
                          output int waited);
        if (dest >= 0) qb[dest].push_back({last, d});
        b_valid = 1'b1; b_sel = 2'(sel); b_data = d; b_last = last;
        waited = 0;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (b_ready) break;
            waited++;
            if (n > 50) begin fail("b_timeout"); break; end
        end
        chk("b_latency0", 32'(b_out_valid), (dest >= 0) ? (32'(1) << dest) : 32'(0));
        @(posedge clk); #1;
        b_valid = 1'b0;
    endtask

    task automatic send_c(input int sel, input logic [7:0] d, input logic last, input int dest);
        if (dest >= 0) qc[dest].push_back({last, d});
        c_valid = 1'b1; c_sel = 1'(sel); c_data = d; c_last = last;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            if (c_ready) break;
            if (n > 50) begin fail("c_timeout"); break; end
        end
        @(posedge clk); #1;
        c_valid = 1'b0;
        c_acc++;
    endtask

    task automatic drain_c();
        for (int n = 0; n < 30 && (qc[0].size() != 0 || qc[1].size() != 0); n++) @(posedge clk);
        #1;
        chk("c_drain", 32'(qc[0].size() + qc[1].size()), 32'(0));
    endtask

    int w;
    int acc0;
    int cyc0;

    initial begin
        rst = 1'b1;
        a_valid = 0; a_data = '0; a_last = 0; a_sel = '0; a_out_ready = '1;
        b_valid = 0; b_data = '0; b_last = 0; b_sel = '0; b_out_ready = '1;
        c_valid = 0; c_data = '0; c_last = 0; c_sel = '0; c_out_ready = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_valid", 32'(a_out_valid), 0);
        chk("rst_c_valid", 32'(c_out_valid), 0);
        chk("rst_c_data",  32'({c_out_last, c_out_data}), 0);
        chk("rst_busy",    32'({a_busy, b_busy, c_busy}), 0);
        chk("rst_sel_err", 32'(b_sel_err), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Select locked on first beat; later in_sel changes ignored.
        send_a(2, 8'hA0, 1'b0, 2);
        chk("a_busy_after_b1", 32'(a_busy), 1);
        send_a(1, 8'hA1, 1'b0, 2);
        send_a(1, 8'hA2, 1'b0, 2);
        chk("a_busy_mid", 32'(a_busy), 1);
        send_a(1, 8'hA3, 1'b1, 2);
        chk("a_busy_after_b4", 32'(a_busy), 0);
        chk("a_drained", 32'(qa[2].size()), 0);

        // Out-of-range select: packet sunk, one sel_err pulse.
        send_b(3, 8'hB0, 1'b0, -1, w);
        chk("b_drop_ready0", 32'(w), 0);
        chk("b_busy_drop", 32'(b_busy), 1);
        send_b(0, 8'hB1, 1'b1, -1, w);
        chk("b_drop_ready1", 32'(w), 0);
        chk("b_busy_end", 32'(b_busy), 0);
        send_b(0, 8'hB2, 1'b1, 0, w);
        chk("b_sel_err_pulses", 32'(b_err_cnt), 1);
        chk("b_drained", 32'(qb[0].size()), 0);

        // Async reset mid-packet discards buffered beats.
        c_out_ready = 2'b01;
        send_c(1, 8'hC0, 1'b0, 1);
        send_c(1, 8'hC1, 1'b0, 1);
        chk("c_busy_pre_rst", 32'(c_busy), 1);
        chk("c_held_pre_rst", 32'(c_out_valid), 32'b10);
        #3 rst = 1'b1;
        #1;
        chk("c_rst_valid", 32'(c_out_valid), 0);
        chk("c_rst_busy", 32'(c_busy), 0);
        qc[0].delete();
        qc[1].delete();
        @(posedge clk); #1;
        rst = 1'b0;
        c_out_ready = 2'b11;
        @(posedge clk); #1;
        send_c(0, 8'hC3, 1'b1, 0);
        chk("c_post_rst_out", 32'(c_out_valid), 32'b01);
        drain_c();

        // Backpressure: skid fills after two beats, then releases in order.
        c_out_ready = 2'b10;
        acc0 = c_acc;
        fork
            begin
                send_c(0, 8'hD0, 1'b0, 0);
                send_c(1, 8'hD1, 1'b0, 0);
                send_c(1, 8'hD2, 1'b0, 0);
                send_c(0, 8'hD3, 1'b1, 0);
            end
            begin
                repeat (6) @(negedge clk);
                chk("c_bp_ready", 32'(c_ready), 0);
                chk("c_bp_accepted", 32'(c_acc - acc0), 2);
                chk("c_bp_hold_data", 32'(c_out_data[7:0]), 32'hD0);
                chk("c_bp_hold_valid", 32'(c_out_valid[0]), 1);
                @(posedge clk); #1;
                c_out_ready[0] = 1'b1;
            end
        join
        drain_c();

        // New packet to output 1 while output 0 still holds a beat.
        c_out_ready = 2'b10;
        send_c(0, 8'hE0, 1'b1, 0);
        send_c(1, 8'hE1, 1'b1, 1);
        chk("c_sw_valid", 32'(c_out_valid), 32'b11);
        chk("c_sw_data1", 32'(c_out_data[15:8]), 32'hE1);
        @(posedge clk); #1;
        c_out_ready = 2'b11;
        drain_c();

        // Back-to-back single-beat packets, one per cycle.
        cyc0 = cyc;
        for (int k = 0; k < 8; k++) begin
            send_c(k % 2, 8'(8'h10 + k), 1'b1, k % 2);
            chk("c_b2b_idle", 32'(c_busy), 0);
        end
        chk("c_b2b_cycles", 32'(cyc - cyc0), 8);
        drain_c();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
